// File: rtl/bp_me_wormhole_packet_decode_lce_req.sv
// Reassembles LCE-to-CCE request wormhole flits into {data, msg_hdr, cid, len, cord}.
// Optional length-overflow flag: define BP_ME_WH_DECODE_LEN_CHECK_EN.
module bp_me_wormhole_packet_decode_lce_req #(
  parameter int flit_width_p    = 64,
  parameter int cord_width_p    = 7,
  parameter int len_width_p     = 4,
  parameter int cid_width_p     = 2,
  parameter int msg_hdr_width_p = 51,
  parameter int data_width_p    = 512,
  localparam int wh_hdr_width_lp = cord_width_p + len_width_p + cid_width_p + msg_hdr_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [flit_width_p-1:0]    link_data_i,
  input  logic                       link_v_i,
  output logic                       link_ready_and_o,
  output logic [wh_hdr_width_lp-1:0] wh_header_o,
  output logic [data_width_p-1:0]    data_o,
  output logic                       v_o,
  input  logic                       ready_and_i,
  output logic                       error_o
);

  localparam int max_flits_lp = (wh_hdr_width_lp + data_width_p + flit_width_p - 1) / flit_width_p;

  localparam logic [1:0] e_ready = 2'd0;
  localparam logic [1:0] e_recv  = 2'd1;
  localparam logic [1:0] e_out   = 2'd2;

  logic [1:0]                                state_r;
  logic [len_width_p-1:0]                    cnt_r;
  logic [len_width_p-1:0]                    len_r;
  logic [max_flits_lp-1:0][flit_width_p-1:0] pkt_r;
  logic [max_flits_lp*flit_width_p-1:0]      pkt_flat;
  logic [len_width_p-1:0]                    len_field;
  logic                                      link_xfer;

  assign len_field        = link_data_i[cord_width_p +: len_width_p];
  assign link_ready_and_o = reset_n_i && (state_r != e_out);
  assign link_xfer        = link_v_i && link_ready_and_o;
  assign v_o              = (state_r == e_out);

  assign pkt_flat    = pkt_r;
  assign wh_header_o = pkt_flat[0 +: wh_hdr_width_lp];
  assign data_o      = pkt_flat[wh_hdr_width_lp +: data_width_p];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
      len_r   <= '0;
      // NOTE: the buffer is reset (not just the control) because undelivered payload must read 0.
      pkt_r   <= '0;
    end else begin
      case (state_r)
        e_ready: if (link_xfer) begin
          // NOTE: non-blocking assignments resolve last-wins, so slot 0 overrides the clear.
          pkt_r    <= '0;
          pkt_r[0] <= link_data_i;
          len_r    <= len_field;
          cnt_r    <= len_width_p'(1);
          state_r  <= (len_field == '0) ? e_out : e_recv;
        end
        e_recv: if (link_xfer) begin
          // Flits beyond the buffer belong to an over-long packet and are dropped.
          if (int'(cnt_r) < max_flits_lp) pkt_r[cnt_r] <= link_data_i;
          if (cnt_r != '1) cnt_r <= cnt_r + len_width_p'(1);
          if (cnt_r == len_r) state_r <= e_out;
        end
        e_out: if (ready_and_i) state_r <= e_ready;
        default: state_r <= e_ready;
      endcase
    end
  end

`ifdef BP_ME_WH_DECODE_LEN_CHECK_EN
  localparam int max_len_lp = max_flits_lp - 1;
  logic error_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      error_r <= 1'b0;
    end else if ((state_r == e_ready) && link_xfer && (int'(len_field) > max_len_lp)) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_wormhole_packet_decode_lce_req.sv
// Directed bench for the LCE request wormhole decoder; expected values are hand-built packets.
module tb_bp_me_wormhole_packet_decode_lce_req;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [63:0]  link_data_i;
  logic         link_v_i;
  logic         link_ready_and_o;
  logic [63:0]  wh_header_o;
  logic [511:0] data_o;
  logic         v_o;
  logic         ready_and_i;
  logic         error_o;

  int errors = 0;
  int checks = 0;

`ifdef BP_ME_WH_DECODE_LEN_CHECK_EN
  localparam logic exp_err_ovf = 1'b1;
`else
  localparam logic exp_err_ovf = 1'b0;
`endif

  bp_me_wormhole_packet_decode_lce_req dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .link_data_i      (link_data_i),
    .link_v_i         (link_v_i),
    .link_ready_and_o (link_ready_and_o),
    .wh_header_o      (wh_header_o),
    .data_o           (data_o),
    .v_o              (v_o),
    .ready_and_i      (ready_and_i),
    .error_o          (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [6:0] cord, input logic [3:0] len,
                                         input logic [1:0] cid, input logic [50:0] msg);
    return {msg, cid, len, cord};
  endfunction

  function automatic logic [63:0] pat(input int i);
    return {32'hDA7A_0000 | 32'(i), 32'h0F11_7000 | 32'(i)};
  endfunction

  // Called at a negedge; returns at the negedge after the flit transferred.
  task automatic send_flit(input logic [63:0] d);
    int n = 0;
    link_data_i = d;
    link_v_i    = 1'b1;
    while (!link_ready_and_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("link_ready", {511'b0, link_ready_and_o}, 512'd1);
    @(posedge clk_i);
    #1;
    link_v_i    = 1'b0;
    link_data_i = '0;
    @(negedge clk_i);
  endtask

  task automatic handoff(input string tag);
    ready_and_i = 1'b1;
    @(negedge clk_i);
    ready_and_i = 1'b0;
    check({tag, "_v_after"}, {511'b0, v_o}, 512'd0);
    check({tag, "_rdy_after"}, {511'b0, link_ready_and_o}, 512'd1);
  endtask

  task automatic apply_reset();
    reset_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    logic [63:0]  h, h2;
    logic [511:0] exp_data;
    logic         stable;

    reset_n_i   = 1'b0;
    link_v_i    = 1'b0;
    link_data_i = '0;
    ready_and_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset state
    check("rst_v", {511'b0, v_o}, 512'd0);
    check("rst_rdy", {511'b0, link_ready_and_o}, 512'd0);
    check("rst_hdr", {448'b0, wh_header_o}, 512'd0);
    check("rst_data", data_o, 512'd0);
    check("rst_err", {511'b0, error_o}, 512'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("rdy_idle", {511'b0, link_ready_and_o}, 512'd1);

    // Header-only packet
    h = mk_hdr(7'd5, 4'd0, 2'd1, 51'h1234);
    send_flit(h);
    check("ho_v", {511'b0, v_o}, 512'd1);
    check("ho_hdr", {448'b0, wh_header_o}, {448'b0, h});
    check("ho_data", data_o, 512'd0);
    check("ho_rdy", {511'b0, link_ready_and_o}, 512'd0);
    handoff("ho");

    // 8-byte request
    h = mk_hdr(7'd3, 4'd1, 2'd0, 51'hABC);
    send_flit(h);
    check("b8_v_mid", {511'b0, v_o}, 512'd0);
    send_flit(64'hDEADBEEF_CAFEF00D);
    check("b8_v", {511'b0, v_o}, 512'd1);
    check("b8_hdr", {448'b0, wh_header_o}, {448'b0, h});
    check("b8_data", data_o, {448'b0, 64'hDEADBEEF_CAFEF00D});
    handoff("b8");

    // Full block, link valid every other cycle
    h = mk_hdr(7'd66, 4'd8, 2'd2, 51'h7_FFFF_0000_1111);
    exp_data = '0;
    send_flit(h);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      if (i == 8) check("fb_v_before", {511'b0, v_o}, 512'd0);
      send_flit(pat(i));
      exp_data[(i-1)*64 +: 64] = pat(i);
    end
    check("fb_v", {511'b0, v_o}, 512'd1);
    check("fb_hdr", {448'b0, wh_header_o}, {448'b0, h});
    check("fb_data", data_o, exp_data);
    handoff("fb");

    // Output backpressure with a second packet waiting on the link
    h  = mk_hdr(7'd9, 4'd0, 2'd3, 51'h55AA);
    h2 = mk_hdr(7'd17, 4'd0, 2'd0, 51'h0BEEF);
    send_flit(h);
    link_v_i    = 1'b1;
    link_data_i = h2;
    stable      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!(v_o === 1'b1 && wh_header_o === h && data_o === 512'd0 && link_ready_and_o === 1'b0))
        stable = 1'b0;
    end
    check("bp_stable", {511'b0, stable}, 512'd1);
    ready_and_i = 1'b1;
    @(negedge clk_i);
    ready_and_i = 1'b0;
    check("bp_v_after", {511'b0, v_o}, 512'd0);
    check("bp_rdy_after", {511'b0, link_ready_and_o}, 512'd1);
    @(posedge clk_i);
    #1;
    link_v_i    = 1'b0;
    link_data_i = '0;
    @(negedge clk_i);
    check("bp2_v", {511'b0, v_o}, 512'd1);
    check("bp2_hdr", {448'b0, wh_header_o}, {448'b0, h2});
    handoff("bp2");

    // Reset mid-packet
    send_flit(mk_hdr(7'd1, 4'd8, 2'd1, 51'h3));
    send_flit(pat(21));
    send_flit(pat(22));
    apply_reset();
    check("mr_v", {511'b0, v_o}, 512'd0);
    check("mr_rdy", {511'b0, link_ready_and_o}, 512'd0);
    check("mr_hdr", {448'b0, wh_header_o}, 512'd0);
    check("mr_data", data_o, 512'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    h = mk_hdr(7'd4, 4'd0, 2'd2, 51'h4321);
    send_flit(h);
    check("mr2_v", {511'b0, v_o}, 512'd1);
    check("mr2_hdr", {448'b0, wh_header_o}, {448'b0, h});
    check("mr2_data", data_o, 512'd0);
    handoff("mr2");

    // Length overflow: len=15, only the first nine slots are kept
    h = mk_hdr(7'd8, 4'd15, 2'd1, 51'h600D);
    exp_data = '0;
    send_flit(h);
    check("ov_err", {511'b0, error_o}, {511'b0, exp_err_ovf});
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) check("ov_v_before", {511'b0, v_o}, 512'd0);
      send_flit(pat(100 + i));
      if (i <= 8) exp_data[(i-1)*64 +: 64] = pat(100 + i);
    end
    check("ov_v", {511'b0, v_o}, 512'd1);
    check("ov_hdr", {448'b0, wh_header_o}, {448'b0, h});
    check("ov_data", data_o, exp_data);
    check("ov_err_hold", {511'b0, error_o}, {511'b0, exp_err_ovf});
    handoff("ov");
    apply_reset();
    check("ov_err_rst", {511'b0, error_o}, 512'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
